// File: rtl/canny_hysteresis.sv
// canny_hysteresis: final Canny stage.
// Classifies the NMS magnitude stream into strong / weak / none against two
// runtime thresholds, then applies single-pass 8-neighbour hysteresis over a
// 3x3 class window fed by two 2-bit line buffers. Emits a binary edge map
// (8'hFF / 8'h00) in raster order. The last row plus one pixel is flushed
// autonomously at end of frame, with class-0 bottom padding.
//
// Window geometry: accepting input (r, x) shifts in the column
// {row r-2, row r-1, row r} at column x. The centre of the window is then the
// middle entry of the previous column, which is linear index k-IMG_W-1. The
// centre position is tracked by its own counters so that out-of-image
// neighbours (including line-wrap aliases) are masked explicitly.
module canny_hysteresis #(
    parameter int IMG_W = 640,
    parameter int IMG_H = 480
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       valid_in,
    input  logic       sof,
    input  logic [7:0] pix_in,
    input  logic [7:0] th_low,
    input  logic [7:0] th_high,
    output logic       in_ready,
    output logic       valid_out,
    output logic [7:0] edge_out,
    output logic       frame_done,
    output logic       err
);

    localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
    localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

    localparam logic [1:0] CLS_NONE   = 2'd0;
    localparam logic [1:0] CLS_WEAK   = 2'd1;
    localparam logic [1:0] CLS_STRONG = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STREAM = 2'd1,
        ST_FLUSH  = 2'd2
    } state_t;

    state_t state_reg, state_next;

    // Input position of the next pixel to be accepted
    logic [CW-1:0] col_reg, col_next;
    logic [RW-1:0] row_reg, row_next;
    // Position of the centre pixel whose output is produced next
    logic [CW-1:0] out_col_reg, out_col_next;
    logic [RW-1:0] out_row_reg, out_row_next;

    logic [7:0] th_low_reg, th_high_reg;

    // Window columns, packed as {top[5:4], mid[3:2], bottom[1:0]}
    logic [5:0] win_l_reg, win_c_reg, win_r_reg;
    logic [5:0] new_col;

    // Line buffers: lb0 holds the previous row, lb1 the row before that
    logic [1:0] lb0_mem [IMG_W];
    logic [1:0] lb1_mem [IMG_W];
    logic [1:0] rd0_reg, rd1_reg;

    logic          accept, restart, flush_step, err_set, adv, emit;
    logic          last_in_pos, out_last;
    logic [CW-1:0] pos_col;
    logic [RW-1:0] pos_row;

    logic [7:0] lo_sel, hi_sel, lo_eff;
    logic [1:0] pix_class;

    logic [7:0][1:0] nb_class;
    logic [7:0]      nb_ok;
    logic [7:0]      nb_strong;
    logic [1:0]      ctr_class;
    logic            top_ok, bot_ok, left_ok, right_ok;
    logic            is_edge;

    assign in_ready    = (state_reg != ST_FLUSH);
    assign last_in_pos = (row_reg == ROW_LAST) && (col_reg == COL_LAST);
    assign out_last    = (out_row_reg == ROW_LAST) && (out_col_reg == COL_LAST);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next state plus accept / restart / error decisions
    always_comb begin
        state_next = state_reg;
        accept     = 1'b0;
        restart    = 1'b0;
        flush_step = 1'b0;
        err_set    = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                // Non-sof pixels while idle are silently ignored
                if (valid_in && sof) begin
                    accept     = 1'b1;
                    restart    = 1'b1;
                    state_next = ST_STREAM;
                end
            end
            ST_STREAM: begin
                if (valid_in) begin
                    accept = 1'b1;
                    if (sof) begin
                        // Mid-frame sof: abandon the current frame, no flush
                        restart = 1'b1;
                        err_set = 1'b1;
                    end else if (last_in_pos) begin
                        state_next = ST_FLUSH;
                    end
                end
            end
            ST_FLUSH: begin
                flush_step = 1'b1;
                if (valid_in) begin
                    err_set = 1'b1;
                end
                if (out_last) begin
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Position bookkeeping for input and centre counters
    always_comb begin
        adv          = accept || flush_step;
        pos_col      = restart ? '0 : col_reg;
        pos_row      = restart ? '0 : row_reg;
        col_next     = col_reg;
        row_next     = row_reg;
        out_col_next = out_col_reg;
        out_row_next = out_row_reg;
        // An output exists once k >= IMG_W+1, i.e. past pixel (1,0)
        emit = flush_step ||
               (accept && (pos_row != '0) && ((pos_row != RW'(1)) || (pos_col != '0)));
        if (adv) begin
            col_next = (pos_col == COL_LAST) ? '0 : pos_col + CW'(1);
        end
        if (accept) begin
            if (pos_col == COL_LAST) begin
                row_next = (pos_row == ROW_LAST) ? '0 : pos_row + RW'(1);
            end else begin
                row_next = pos_row;
            end
        end
        if (restart) begin
            out_col_next = '0;
            out_row_next = '0;
        end else if (emit) begin
            if (out_col_reg == COL_LAST) begin
                out_col_next = '0;
                out_row_next = (out_row_reg == ROW_LAST) ? '0 : out_row_reg + RW'(1);
            end else begin
                out_col_next = out_col_reg + CW'(1);
            end
        end
    end

    // Counter registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_reg     <= '0;
            row_reg     <= '0;
            out_col_reg <= '0;
            out_row_reg <= '0;
        end else begin
            col_reg     <= col_next;
            row_reg     <= row_next;
            out_col_reg <= out_col_next;
            out_row_reg <= out_row_next;
        end
    end

    // Threshold latch on every accepted sof
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            th_low_reg  <= 8'd0;
            th_high_reg <= 8'd0;
        end else if (restart) begin
            th_low_reg  <= th_low;
            th_high_reg <= th_high;
        end
    end

    // Pixel classification; the sof pixel uses the live thresholds
    always_comb begin
        lo_sel    = restart ? th_low  : th_low_reg;
        hi_sel    = restart ? th_high : th_high_reg;
        // An inverted pair collapses the weak band to nothing
        lo_eff    = (lo_sel > hi_sel) ? hi_sel : lo_sel;
        pix_class = CLS_NONE;
        if (!flush_step) begin
            if (pix_in >= hi_sel) begin
                pix_class = CLS_STRONG;
            end else if (pix_in >= lo_eff) begin
                pix_class = CLS_WEAK;
            end
        end
    end

    assign new_col = {rd1_reg, rd0_reg, pix_class};

    // Line buffers with registered read. The read address is the column of
    // the next pixel, so rd*_reg always mirrors lbX_mem[col_reg]; the write
    // address (current column) never equals it because IMG_W >= 3.
    always_ff @(posedge clk) begin
        if (adv) begin
            lb0_mem[pos_col] <= pix_class;
            lb1_mem[pos_col] <= rd0_reg;
        end
        rd0_reg <= lb0_mem[col_next];
        rd1_reg <= lb1_mem[col_next];
    end

    // 3x3 window shift, one column per accepted pixel or flush step
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            win_l_reg <= '0;
            win_c_reg <= '0;
            win_r_reg <= '0;
        end else if (adv) begin
            win_l_reg <= win_c_reg;
            win_c_reg <= win_r_reg;
            win_r_reg <= new_col;
        end
    end

    // Neighbourhood of the centre after this shift, with image-edge masks
    always_comb begin
        top_ok    = (out_row_reg != '0);
        bot_ok    = (out_row_reg != ROW_LAST);
        left_ok   = (out_col_reg != '0);
        right_ok  = (out_col_reg != COL_LAST);
        ctr_class = win_r_reg[3:2];
        nb_class[0] = win_c_reg[5:4];  nb_ok[0] = top_ok && left_ok;
        nb_class[1] = win_r_reg[5:4];  nb_ok[1] = top_ok;
        nb_class[2] = new_col[5:4];    nb_ok[2] = top_ok && right_ok;
        nb_class[3] = win_c_reg[3:2];  nb_ok[3] = left_ok;
        nb_class[4] = new_col[3:2];    nb_ok[4] = right_ok;
        nb_class[5] = win_c_reg[1:0];  nb_ok[5] = bot_ok && left_ok;
        nb_class[6] = win_r_reg[1:0];  nb_ok[6] = bot_ok;
        nb_class[7] = new_col[1:0];    nb_ok[7] = bot_ok && right_ok;
    end

    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_nb
            assign nb_strong[gi] = nb_ok[gi] && (nb_class[gi] == CLS_STRONG);
        end
    endgenerate

    assign is_edge = (ctr_class == CLS_STRONG) ||
                     ((ctr_class == CLS_WEAK) && (|nb_strong));

    // Registered output stage
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_out  <= 1'b0;
            edge_out   <= 8'h00;
            frame_done <= 1'b0;
        end else begin
            valid_out  <= emit;
            edge_out   <= (emit && is_edge) ? 8'hFF : 8'h00;
            frame_done <= emit && flush_step && out_last;
        end
    end

    // Sticky error flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err <= 1'b0;
        end else if (err_set) begin
            err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_canny_hysteresis.sv
// Bench for canny_hysteresis on a 4x3 image: directed cases plus randomized
// frames, scored against a frame-level hysteresis model with cycle timing.
module tb_canny_hysteresis;

    localparam int W = 4;
    localparam int H = 3;
    localparam int N = W * H;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       valid_in = 1'b0;
    logic       sof = 1'b0;
    logic [7:0] pix_in = 8'd0;
    logic [7:0] th_low = 8'd0;
    logic [7:0] th_high = 8'd0;
    logic       in_ready;
    logic       valid_out;
    logic [7:0] edge_out;
    logic       frame_done;
    logic       err;

    canny_hysteresis #(.IMG_W(W), .IMG_H(H)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .valid_in   (valid_in),
        .sof        (sof),
        .pix_in     (pix_in),
        .th_low     (th_low),
        .th_high    (th_high),
        .in_ready   (in_ready),
        .valid_out  (valid_out),
        .edge_out   (edge_out),
        .frame_done (frame_done),
        .err        (err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int cyc;
        int val;
        int last;
        int idx;
    } ent_t;

    ent_t q[$];
    ent_t mon_e;
    int   img[N];
    int   exp_edge[N];
    int   cap[N];
    int   n_total = 0;
    int   n_bad = 0;
    int   cyc = 0;
    int   low_run = 0;
    bit   mon_en = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_total++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %0d (0x%0h) want %0d (0x%0h) at cycle %0d",
                     tag, got, got, want, want, cyc);
        end
    endtask

    function automatic int classify(input int p, input int lo, input int hi);
        int lo_eff;
        lo_eff = (lo > hi) ? hi : lo;
        if (p >= hi) return 2;
        if (p >= lo_eff) return 1;
        return 0;
    endfunction

    // Whole-frame reference: classify every pixel, then apply the 8-neighbour rule
    function automatic void build_expected(input int lo, input int hi);
        int cls[N];
        int c, hit, ny, nx;
        for (int i = 0; i < N; i++) cls[i] = classify(img[i], lo, hi);
        for (int y = 0; y < H; y++) begin
            for (int x = 0; x < W; x++) begin
                c = cls[y*W + x];
                hit = 0;
                for (int dy = -1; dy <= 1; dy++) begin
                    for (int dx = -1; dx <= 1; dx++) begin
                        ny = y + dy;
                        nx = x + dx;
                        if ((dy != 0 || dx != 0) && ny >= 0 && ny < H && nx >= 0 && nx < W)
                            if (cls[ny*W + nx] == 2) hit = 1;
                    end
                end
                exp_edge[y*W + x] = (c == 2 || (c == 1 && hit == 1)) ? 255 : 0;
            end
        end
    endfunction

    function automatic int rnd_pix(input int lo, input int hi);
        int v;
        case ($urandom_range(4, 0))
            0: v = 0;
            1: v = lo + int'($urandom_range(2, 0)) - 1;
            2: v = hi + int'($urandom_range(2, 0)) - 1;
            default: v = int'($urandom_range(255, 0));
        endcase
        if (v < 0) v = 0;
        if (v > 255) v = 255;
        return v;
    endfunction

    // Output scoreboard and in_ready low-window measurement
    always @(negedge clk) begin
        if (mon_en) begin
            if (valid_out) begin
                if (q.size() == 0) begin
                    chk("extra_out", 32'd1, 32'd0);
                end else begin
                    mon_e = q.pop_front();
                    chk("out_cycle", cyc, mon_e.cyc);
                    chk("edge", {24'd0, edge_out}, mon_e.val);
                    chk("frame_done", {31'd0, frame_done}, mon_e.last);
                    cap[mon_e.idx] = edge_out;
                end
            end else if (q.size() != 0 && q[0].cyc < cyc) begin
                chk("missing_out", cyc, q[0].cyc);
                void'(q.pop_front());
            end
            if (!in_ready) begin
                low_run++;
            end else if (low_run != 0) begin
                chk("in_ready_low_cycles", low_run, W + 1);
                low_run = 0;
            end
        end
    end

    // Drive n_pix pixels of img[]; after sof the threshold inputs are scrambled
    task automatic drive_frame(input int lo, input int hi, input int n_pix, input int gap_max);
        ent_t e;
        int   c_last;
        c_last = 0;
        build_expected(lo, hi);
        for (int j = 0; j < n_pix; j++) begin
            if (gap_max > 0 && $urandom_range(3, 0) == 0) begin
                valid_in = 1'b0;
                sof = 1'b0;
                repeat ($urandom_range(gap_max, 1)) begin
                    @(posedge clk);
                    #1;
                end
            end
            valid_in = 1'b1;
            sof = (j == 0);
            pix_in = 8'(img[j]);
            if (j == 0) begin
                th_low = 8'(lo);
                th_high = 8'(hi);
            end else begin
                th_low = 8'($urandom);
                th_high = 8'($urandom);
            end
            if (j >= W + 1) begin
                e.cyc = cyc + 1;
                e.idx = j - W - 1;
                e.val = exp_edge[e.idx];
                e.last = 0;
                q.push_back(e);
            end
            c_last = cyc;
            @(posedge clk);
            #1;
        end
        valid_in = 1'b0;
        sof = 1'b0;
        if (n_pix == N) begin
            chk("in_ready_fall", {31'd0, in_ready}, 32'd0);
            for (int i = 0; i <= W; i++) begin
                e.cyc = c_last + 2 + i;
                e.idx = N - W - 1 + i;
                e.val = exp_edge[e.idx];
                e.last = (i == W) ? 1 : 0;
                q.push_back(e);
            end
        end
    endtask

    task automatic drain(input string tag);
        int i;
        i = 0;
        while ((q.size() != 0 || !in_ready) && i < 200) begin
            @(posedge clk);
            #1;
            i++;
        end
        chk(tag, q.size(), 0);
        repeat (3) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        mon_en = 1'b0;
        valid_in = 1'b0;
        sof = 1'b0;
        rst_n = 1'b0;
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        rst_n = 1'b1;
        q.delete();
        low_run = 0;
        mon_en = 1'b1;
    endtask

    task automatic clear_img();
        for (int i = 0; i < N; i++) img[i] = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int lo, hi;

        // Reset values while reset is held
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        chk("rst_valid_out", {31'd0, valid_out}, 32'd0);
        chk("rst_edge_out", {24'd0, edge_out}, 32'd0);
        chk("rst_frame_done", {31'd0, frame_done}, 32'd0);
        chk("rst_err", {31'd0, err}, 32'd0);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        rst_n = 1'b1;
        mon_en = 1'b1;

        // Zero frame
        clear_img();
        drive_frame(50, 100, N, 0);
        drain("drain_zero");
        for (int i = 0; i < N; i++) chk("zero_frame_px", cap[i], 0);
        chk("zero_err", {31'd0, err}, 32'd0);

        // Weak pixel linked to strong, isolated weak pixel
        clear_img();
        img[1*W+1] = 120;
        img[1*W+2] = 60;
        img[0*W+3] = 60;
        drive_frame(50, 100, N, 0);
        drain("drain_link");
        chk("link_strong_1_1", cap[1*W+1], 255);
        chk("link_weak_1_2", cap[1*W+2], 255);
        chk("isolated_weak_0_3", cap[0*W+3], 0);

        // Line-wrap aliasing must not count as adjacency
        clear_img();
        img[0*W+3] = 120;
        img[1*W+0] = 60;
        drive_frame(50, 100, N, 0);
        drain("drain_wrap");
        chk("wrap_strong_0_3", cap[0*W+3], 255);
        chk("wrap_weak_1_0", cap[1*W+0], 0);

        // Inverted thresholds: no weak class
        clear_img();
        img[1*W+1] = 150;
        img[1*W+2] = 90;
        drive_frame(200, 100, N, 0);
        drain("drain_inv");
        chk("inv_strong", cap[1*W+1], 255);
        chk("inv_below_high", cap[1*W+2], 0);

        // valid_in during FLUSH: pixel dropped, err set, frame still complete
        for (int i = 0; i < N; i++) img[i] = rnd_pix(60, 140);
        drive_frame(60, 140, N, 0);
        chk("err_before_flush_pulse", {31'd0, err}, 32'd0);
        valid_in = 1'b1;
        pix_in = 8'($urandom);
        @(posedge clk);
        #1;
        valid_in = 1'b0;
        chk("err_flush_pulse", {31'd0, err}, 32'd1);
        drain("drain_flush_pulse");
        for (int i = 0; i < N; i++) img[i] = rnd_pix(30, 90);
        drive_frame(30, 90, N, 0);
        drain("drain_after_pulse");
        chk("err_sticky", {31'd0, err}, 32'd1);

        // Mid-frame sof after 7 pixels
        do_reset();
        chk("err_after_reset", {31'd0, err}, 32'd0);
        for (int i = 0; i < N; i++) img[i] = rnd_pix(40, 120);
        drive_frame(40, 120, 7, 0);
        for (int i = 0; i < N; i++) img[i] = rnd_pix(70, 110);
        drive_frame(70, 110, N, 0);
        chk("err_abort", {31'd0, err}, 32'd1);
        drain("drain_abort");

        // Asynchronous reset in the middle of a frame
        for (int i = 0; i < N; i++) img[i] = rnd_pix(40, 120);
        drive_frame(40, 120, 9, 0);
        chk("pre_reset_valid_out", {31'd0, valid_out}, 32'd1);
        mon_en = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_valid_out", {31'd0, valid_out}, 32'd0);
        chk("async_rst_err", {31'd0, err}, 32'd0);
        chk("async_rst_in_ready", {31'd0, in_ready}, 32'd1);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        q.delete();
        low_run = 0;
        mon_en = 1'b1;

        // Randomized frames with input gaps and idle-time noise
        for (int f = 0; f < 25; f++) begin
            lo = int'($urandom_range(255, 0));
            hi = int'($urandom_range(255, 0));
            for (int i = 0; i < N; i++) img[i] = rnd_pix(lo, hi);
            drive_frame(lo, hi, N, 3);
            drain("drain_rand");
            if ($urandom_range(1, 0) == 1) begin
                valid_in = 1'b1;
                sof = 1'b0;
                pix_in = 8'($urandom);
                repeat ($urandom_range(3, 1)) begin
                    @(posedge clk);
                    #1;
                end
                valid_in = 1'b0;
                repeat (2) begin
                    @(posedge clk);
                    #1;
                end
                chk("idle_noise_err", {31'd0, err}, 32'd0);
                chk("idle_noise_no_out", q.size(), 0);
            end
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
